// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the two requester handshakes and the cache memory port.
// The arbiter connects via the slave modport; requesters and the
// memory model connect via the master modport.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  // Requester 0
  logic              p0_req_valid;
  logic              p0_req_ready;
  logic              p0_req_wr;
  logic [ADDR_W-1:0] p0_req_addr;
  logic [DATA_W-1:0] p0_req_wdata;
  logic              p0_rsp_valid;
  logic [DATA_W-1:0] p0_rsp_rdata;
  // Requester 1
  logic              p1_req_valid;
  logic              p1_req_ready;
  logic              p1_req_wr;
  logic [ADDR_W-1:0] p1_req_addr;
  logic [DATA_W-1:0] p1_req_wdata;
  logic              p1_rsp_valid;
  logic [DATA_W-1:0] p1_rsp_rdata;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  p0_req_valid, p0_req_wr, p0_req_addr, p0_req_wdata,
    output p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
    input  p1_req_valid, p1_req_wr, p1_req_addr, p1_req_wdata,
    output p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
    output mem_addr, mem_data_in, mem_wr_en, mem_rd_en,
    input  mem_data_out
  );

  modport master (
    output p0_req_valid, p0_req_wr, p0_req_addr, p0_req_wdata,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
    output p1_req_valid, p1_req_wr, p1_req_addr, p1_req_wdata,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
    input  mem_addr, mem_data_in, mem_wr_en, mem_rd_en,
    output mem_data_out
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a 32x8 cache memory.
// One transaction in flight: IDLE -> ISSUE -> (RD_WAIT) -> RESP -> IDLE.
// Round-robin between p0 and p1 by default; define
// CACHE_MEM_ARB_FIXED_PRIO_EN for fixed priority (p0 always wins ties).
module cache_mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  cache_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q;
  logic              grant_q;       // requester owning the in-flight op
  logic              lat_wr_q;      // in-flight op is a write
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_wr_en_q;
  logic              mem_rd_en_q;
  logic              p0_rsp_valid_q;
  logic              p1_rsp_valid_q;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
  logic              last_grant_q;  // requester granted most recently
`endif

  logic              win_vld_d;
  logic              win_id_d;
  logic              sel_wr_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  // Winner selection; only meaningful while idle and out of reset
  always_comb begin
    win_vld_d = 1'b0;
    win_id_d  = 1'b0;
    if ((state_q == IDLE) && rst_n) begin
      win_vld_d = bus.p0_req_valid | bus.p1_req_valid;
      if (bus.p0_req_valid && bus.p1_req_valid) begin
`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
        win_id_d = 1'b0;
`else
        win_id_d = ~last_grant_q;
`endif
      end else if (bus.p1_req_valid) begin
        win_id_d = 1'b1;
      end else begin
        win_id_d = 1'b0;
      end
    end else begin
      win_vld_d = 1'b0;
      win_id_d  = 1'b0;
    end
  end

  // Request fields of the current winner
  always_comb begin
    sel_wr_d    = 1'b0;
    sel_addr_d  = {ADDR_W{1'b0}};
    sel_wdata_d = {DATA_W{1'b0}};
    if (win_id_d) begin
      sel_wr_d    = bus.p1_req_wr;
      sel_addr_d  = bus.p1_req_addr;
      sel_wdata_d = bus.p1_req_wdata;
    end else begin
      sel_wr_d    = bus.p0_req_wr;
      sel_addr_d  = bus.p0_req_addr;
      sel_wdata_d = bus.p0_req_wdata;
    end
  end

  // Sequencer FSM with registered memory strobes and responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      lat_wr_q       <= 1'b0;
      mem_addr_q     <= {ADDR_W{1'b0}};
      mem_data_q     <= {DATA_W{1'b0}};
      mem_wr_en_q    <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      p0_rsp_valid_q <= 1'b0;
      p1_rsp_valid_q <= 1'b0;
      p0_rdata_q     <= {DATA_W{1'b0}};
      p1_rdata_q     <= {DATA_W{1'b0}};
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
      last_grant_q   <= 1'b1;  // p0 wins the first tie after reset
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            grant_q      <= win_id_d;
            lat_wr_q     <= sel_wr_d;
            mem_addr_q   <= sel_addr_d;
            mem_data_q   <= sel_wdata_d;
            mem_wr_en_q  <= sel_wr_d;
            mem_rd_en_q  <= ~sel_wr_d;
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
            last_grant_q <= win_id_d;
`endif
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_wr_en_q <= 1'b0;
          mem_rd_en_q <= 1'b0;
          if (lat_wr_q) begin
            // Write completion: rdata registers are left untouched
            p0_rsp_valid_q <= ~grant_q;
            p1_rsp_valid_q <= grant_q;
            state_q        <= RESP;
          end else begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Memory output is registered, so read data is valid here
          if (grant_q) begin
            p1_rdata_q <= bus.mem_data_out;
          end else begin
            p0_rdata_q <= bus.mem_data_out;
          end
          p0_rsp_valid_q <= ~grant_q;
          p1_rsp_valid_q <= grant_q;
          state_q        <= RESP;
        end
        RESP: begin
          p0_rsp_valid_q <= 1'b0;
          p1_rsp_valid_q <= 1'b0;
          state_q        <= IDLE;
        end
        default: begin
          mem_wr_en_q    <= 1'b0;
          mem_rd_en_q    <= 1'b0;
          p0_rsp_valid_q <= 1'b0;
          p1_rsp_valid_q <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign bus.p0_req_ready = win_vld_d & ~win_id_d;
  assign bus.p1_req_ready = win_vld_d & win_id_d;
  assign bus.p0_rsp_valid = p0_rsp_valid_q;
  assign bus.p1_rsp_valid = p1_rsp_valid_q;
  assign bus.p0_rsp_rdata = p0_rdata_q;
  assign bus.p1_rsp_rdata = p1_rdata_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_in  = mem_data_q;
  assign bus.mem_wr_en    = mem_wr_en_q;
  assign bus.mem_rd_en    = mem_rd_en_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a 32x8 memory device, directed scenarios
// and randomized traffic checked against a transaction-level model.
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Memory device: registered read, contents preset while in reset
  logic [7:0] dev_mem [32];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) dev_mem[i] <= 8'(i) ^ 8'h3C;
      bus.mem_data_out <= 8'h00;
    end else begin
      if (bus.mem_wr_en) dev_mem[bus.mem_addr] <= bus.mem_data_in;
      if (bus.mem_rd_en) bus.mem_data_out <= dev_mem[bus.mem_addr];
    end
  end

  // Reference model state
  logic [7:0] ref_mem [32];
  logic [7:0] exp_rdata [2];
  bit         model_last;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    model_last = 1'b1;
  endtask

  function automatic int exp_winner(bit v0, bit v1);
`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
    if (v0) return 0;
    return 1;
`else
    if (v0 && v1) return model_last ? 0 : 1;
    if (v0) return 0;
    return 1;
`endif
  endfunction

  task automatic model_commit(input int win, input bit wr, input logic [4:0] a, input logic [7:0] d);
    model_last = (win == 1);
    if (wr) ref_mem[a] = d;
    else exp_rdata[win] = ref_mem[a];
  endtask

  // Enable monitor: a strobe appears exactly in the cycle after a handshake
  bit mon_on = 1'b0;
  bit hs_prev = 1'b0;
  bit hs_wr_prev = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      n_total++;
      if ({bus.mem_wr_en, bus.mem_rd_en} !== {hs_prev & hs_wr_prev, hs_prev & ~hs_wr_prev})
        $display("FAIL mem_enables cyc=%0d: got wr/rd=%b%b expected %b%b", cyc,
                 bus.mem_wr_en, bus.mem_rd_en, hs_prev & hs_wr_prev, hs_prev & ~hs_wr_prev);
      else n_pass++;
    end
    hs_prev    = rst_n & ((bus.p0_req_valid & bus.p0_req_ready) | (bus.p1_req_valid & bus.p1_req_ready));
    hs_wr_prev = (bus.p0_req_valid & bus.p0_req_ready) ? bus.p0_req_wr : bus.p1_req_wr;
  end

  task automatic clear_reqs();
    bus.p0_req_valid = 1'b0; bus.p0_req_wr = 1'b0; bus.p0_req_addr = 5'd0; bus.p0_req_wdata = 8'h00;
    bus.p1_req_valid = 1'b0; bus.p1_req_wr = 1'b0; bus.p1_req_addr = 5'd0; bus.p1_req_wdata = 8'h00;
  endtask

  // Present up to two requests, wait for one acceptance and its response
  task automatic do_pair(input bit v0, input bit w0, input logic [4:0] a0, input logic [7:0] d0,
                         input bit v1, input bit w1, input logic [4:0] a1, input logic [7:0] d1,
                         output int win, output int acc_c, output int rsp_c,
                         output logic [7:0] rdata, output bit other_rsp, output bit tmo);
    win = -1; acc_c = 0; rsp_c = 0; rdata = 8'h00; other_rsp = 1'b0; tmo = 1'b1;
    @(posedge clk); #1;
    bus.p0_req_valid = v0; bus.p0_req_wr = w0; bus.p0_req_addr = a0; bus.p0_req_wdata = d0;
    bus.p1_req_valid = v1; bus.p1_req_wr = w1; bus.p1_req_addr = a1; bus.p1_req_wdata = d1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.p0_req_valid && bus.p0_req_ready) begin win = 0; break; end
      if (bus.p1_req_valid && bus.p1_req_ready) begin win = 1; break; end
    end
    if (win < 0) begin
      clear_reqs();
      return;
    end
    acc_c = cyc;
    @(posedge clk); #1;
    clear_reqs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((win == 0) ? bus.p1_rsp_valid : bus.p0_rsp_valid) other_rsp = 1'b1;
      if ((win == 0) ? bus.p0_rsp_valid : bus.p1_rsp_valid) begin
        rsp_c = cyc;
        rdata = (win == 0) ? bus.p0_rsp_rdata : bus.p1_rsp_rdata;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_reqs();
    rst_n = 1'b0;
    bus.p0_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bus.p0_req_ready, bus.p1_req_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b expected 00", {bus.p0_req_ready, bus.p1_req_ready});
    else n_pass++;
    n_total++;
    if ({bus.p0_rsp_valid, bus.p1_rsp_valid, bus.mem_wr_en, bus.mem_rd_en} !== 4'b0000)
      $display("FAIL reset_strobes: got %b expected 0000",
               {bus.p0_rsp_valid, bus.p1_rsp_valid, bus.mem_wr_en, bus.mem_rd_en});
    else n_pass++;
    n_total++;
    if ({bus.mem_addr, bus.mem_data_in} !== 13'd0)
      $display("FAIL reset_mem_bus: got %h/%h expected 00/00", bus.mem_addr, bus.mem_data_in);
    else n_pass++;
    n_total++;
    if ({bus.p0_rsp_rdata, bus.p1_rsp_rdata} !== 16'h0000)
      $display("FAIL reset_rdata: got %h/%h expected 00/00", bus.p0_rsp_rdata, bus.p1_rsp_rdata);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_reqs();
    model_reset();
    mon_on = 1'b1;
  endtask

  task automatic test_contention();
    int win, acc_c, rsp_c, ew; logic [7:0] rd; bit oth, tmo;
    for (int k = 0; k < 4; k++) begin
      ew = exp_winner(1'b1, 1'b1);
      do_pair(1'b1, 1'b1, 5'd1, 8'h11, 1'b1, 1'b1, 5'd2, 8'h22, win, acc_c, rsp_c, rd, oth, tmo);
      n_total++;
      if (tmo || win != ew) $display("FAIL contention_grant[%0d]: got %0d (tmo=%0d) expected %0d", k, win, tmo, ew);
      else n_pass++;
      n_total++;
      if (rsp_c - acc_c != 2 || oth) $display("FAIL contention_rsp[%0d]: got latency %0d other=%0d expected 2/0", k, rsp_c - acc_c, oth);
      else n_pass++;
      model_commit(ew, 1'b1, (ew == 0) ? 5'd1 : 5'd2, (ew == 0) ? 8'h11 : 8'h22);
    end
    do_pair(1'b1, 1'b0, 5'd1, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || rd !== 8'h11) $display("FAIL contention_rb0: got %h expected 11", rd);
    else n_pass++;
    model_commit(0, 1'b0, 5'd1, 8'h00);
    do_pair(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd2, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || rd !== 8'h22 || rsp_c - acc_c != 3) $display("FAIL contention_rb1: got %h lat %0d expected 22 lat 3", rd, rsp_c - acc_c);
    else n_pass++;
    model_commit(1, 1'b0, 5'd2, 8'h00);
  endtask

  task automatic test_write_read();
    int win, acc_c, rsp_c; logic [7:0] rd; bit oth, tmo;
    do_pair(1'b1, 1'b1, 5'd5, 8'hA5, 1'b0, 1'b0, 5'd0, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || win != 0 || rsp_c - acc_c != 2 || oth)
      $display("FAIL write_latency: got win %0d lat %0d other %0d expected 0/2/0", win, rsp_c - acc_c, oth);
    else n_pass++;
    model_commit(0, 1'b1, 5'd5, 8'hA5);
    do_pair(1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || rsp_c - acc_c != 3 || oth)
      $display("FAIL read_latency: got lat %0d other %0d expected 3/0", rsp_c - acc_c, oth);
    else n_pass++;
    n_total++;
    if (rd !== 8'hA5) $display("FAIL read_data: got %h expected a5", rd);
    else n_pass++;
    model_commit(0, 1'b0, 5'd5, 8'h00);
  endtask

  task automatic test_cross();
    int win, acc_c, rsp_c; logic [7:0] rd; bit oth, tmo;
    do_pair(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd31, 8'hFF, win, acc_c, rsp_c, rd, oth, tmo);
    model_commit(1, 1'b1, 5'd31, 8'hFF);
    do_pair(1'b1, 1'b0, 5'd31, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || rd !== 8'hFF) $display("FAIL cross_addr31: got %h expected ff", rd);
    else n_pass++;
    model_commit(0, 1'b0, 5'd31, 8'h00);
    do_pair(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || rd !== 8'h3C) $display("FAIL cross_addr0: got %h expected 3c", rd);
    else n_pass++;
    model_commit(0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic test_back_to_back();
    int win, acc_c, rsp_c, prev_rsp; logic [7:0] rd, first_rd; bit oth, tmo;
    do_pair(1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, win, acc_c, rsp_c, first_rd, oth, tmo);
    model_commit(0, 1'b0, 5'd7, 8'h00);
    prev_rsp = rsp_c;
    do_pair(1'b1, 1'b1, 5'd7, 8'h5A, 1'b0, 1'b0, 5'd0, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || acc_c - prev_rsp != 1) $display("FAIL b2b_accept: got gap %0d expected 1", acc_c - prev_rsp);
    else n_pass++;
    n_total++;
    if (rd !== first_rd || rd !== exp_rdata[0]) $display("FAIL b2b_write_keeps_rdata: got %h expected %h", rd, exp_rdata[0]);
    else n_pass++;
    model_commit(0, 1'b1, 5'd7, 8'h5A);
    do_pair(1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || rd !== 8'h5A) $display("FAIL b2b_readback: got %h expected 5a", rd);
    else n_pass++;
    model_commit(0, 1'b0, 5'd7, 8'h00);
  endtask

  task automatic test_reset_mid_read();
    int win, acc_c, rsp_c; logic [7:0] rd; bit oth, tmo, seen, accepted;
    accepted = 1'b0;
    @(posedge clk); #1;
    bus.p1_req_valid = 1'b1; bus.p1_req_wr = 1'b0; bus.p1_req_addr = 5'd2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.p1_req_ready) begin accepted = 1'b1; break; end
    end
    n_total++;
    if (!accepted) $display("FAIL midrst_accept: got no ready expected ready");
    else n_pass++;
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);  // ISSUE
    @(negedge clk);  // RD_WAIT
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bus.p1_rsp_valid, bus.p0_rsp_valid, bus.mem_wr_en, bus.mem_rd_en} !== 4'b0000)
      $display("FAIL midrst_strobes: got %b expected 0000",
               {bus.p1_rsp_valid, bus.p0_rsp_valid, bus.mem_wr_en, bus.mem_rd_en});
    else n_pass++;
    n_total++;
    if ({bus.p0_rsp_rdata, bus.p1_rsp_rdata, bus.mem_addr, bus.mem_data_in} !== 29'd0)
      $display("FAIL midrst_data: got %h/%h/%h/%h expected zeros",
               bus.p0_rsp_rdata, bus.p1_rsp_rdata, bus.mem_addr, bus.mem_data_in);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.p1_rsp_valid) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL midrst_no_rsp: got p1_rsp_valid=1 expected 0");
    else n_pass++;
    do_pair(1'b1, 1'b1, 5'd9, 8'h99, 1'b1, 1'b1, 5'd10, 8'hAA, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || win != 0) $display("FAIL midrst_first_grant: got %0d expected 0", win);
    else n_pass++;
    model_commit(0, 1'b1, 5'd9, 8'h99);
  endtask

`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int win, acc_c, rsp_c; logic [7:0] rd; bit oth, tmo;
    for (int k = 0; k < 3; k++) begin
      do_pair(1'b1, 1'b1, 5'(12 + k), 8'(8'h40 + k), 1'b1, 1'b0, 5'd3, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
      n_total++;
      if (tmo || win != 0) $display("FAIL fixed_prio[%0d]: got %0d expected 0", k, win);
      else n_pass++;
      model_commit(0, 1'b1, 5'(12 + k), 8'(8'h40 + k));
    end
    do_pair(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd3, 8'h00, win, acc_c, rsp_c, rd, oth, tmo);
    n_total++;
    if (tmo || win != 1 || rd !== ref_mem[3]) $display("FAIL fixed_prio_p1: got %0d/%h expected 1/%h", win, rd, ref_mem[3]);
    else n_pass++;
    model_commit(1, 1'b0, 5'd3, 8'h00);
  endtask
`endif

  task automatic test_random();
    int win, acc_c, rsp_c, ew, sel; logic [7:0] rd, er, ed; logic [4:0] ea; bit oth, tmo, ewr;
    bit v0, v1, w0, w1; logic [4:0] a0, a1; logic [7:0] d0, d1;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(2, 0);
      v0 = (sel != 1); v1 = (sel != 0);
      w0 = 1'($urandom_range(1, 0)); w1 = 1'($urandom_range(1, 0));
      a0 = 5'($urandom_range(31, 0)); a1 = 5'($urandom_range(31, 0));
      d0 = 8'($urandom_range(255, 0)); d1 = 8'($urandom_range(255, 0));
      ew  = exp_winner(v0, v1);
      ewr = (ew == 0) ? w0 : w1;
      ea  = (ew == 0) ? a0 : a1;
      ed  = (ew == 0) ? d0 : d1;
      er  = ewr ? exp_rdata[ew] : ref_mem[ea];
      do_pair(v0, w0, a0, d0, v1, w1, a1, d1, win, acc_c, rsp_c, rd, oth, tmo);
      n_total++;
      if (tmo || win != ew) $display("FAIL rand_grant[%0d]: got %0d (tmo=%0d) expected %0d", k, win, tmo, ew);
      else n_pass++;
      n_total++;
      if (rsp_c - acc_c != (ewr ? 2 : 3) || oth)
        $display("FAIL rand_latency[%0d]: got %0d other=%0d expected %0d/0", k, rsp_c - acc_c, oth, ewr ? 2 : 3);
      else n_pass++;
      n_total++;
      if (rd !== er) $display("FAIL rand_rdata[%0d]: got %h expected %h", k, rd, er);
      else n_pass++;
      model_commit(ew, ewr, ea, ed);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_write_read();
    test_cross();
    test_back_to_back();
    test_reset_mid_read();
`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time %0t expected finish", $time);
    $fatal(1);
  end

endmodule
